ace_snoop_initiator: RTL and testbench

- Interconnect-side master for the ACE snoop channels: it drives AC and collects the CR response and any CD data from one cached master.
- Accepts one snoop command at a time from the coherency controller, issues it on AC, waits for CR, optionally gathers a full cache line on CD, then returns the result.
- Sits between the CCU snoop arbiter and each cache port's snoop_req/snoop_resp pair.
- One outstanding snoop per instance.

---
 rtl/ace_snoop_initiator.sv | 128 ++++++++++++
 tb/tb_ace_snoop_initiator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ace_snoop_initiator.sv
// rtl/ace_snoop_initiator.sv - ACE snoop channel master: issues AC, collects CR and optional CD line.
// One outstanding snoop; every handshake output is a flop loaded from the next state.
module ace_snoop_initiator #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int CdBeats   = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [AddrWidth-1:0]          req_addr_i,
  input  logic [3:0]                    req_snoop_i,
  input  logic [2:0]                    req_prot_i,
  output logic                          ac_valid_o,
  input  logic                          ac_ready_i,
  output logic [AddrWidth-1:0]          ac_addr_o,
  output logic [3:0]                    ac_snoop_o,
  output logic [2:0]                    ac_prot_o,
  input  logic                          cr_valid_i,
  output logic                          cr_ready_o,
  input  logic [4:0]                    cr_resp_i,
  input  logic                          cd_valid_i,
  output logic                          cd_ready_o,
  input  logic [DataWidth-1:0]          cd_data_i,
  input  logic                          cd_last_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [4:0]                    rsp_crresp_o,
  output logic [DataWidth*CdBeats-1:0]  rsp_data_o,
  output logic                          rsp_err_o
);

  localparam int CntW = (CdBeats > 1) ? $clog2(CdBeats) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CdBeats - 1);

  typedef enum logic [2:0] {S_IDLE, S_AC, S_CR, S_CD, S_RSP} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          r_req_ready;
  logic                          r_ac_valid;
  logic                          r_cr_ready;
  logic                          r_cd_ready;
  logic                          r_rsp_valid;
  logic [AddrWidth-1:0]          r_ac_addr;
  logic [3:0]                    r_ac_snoop;
  logic [2:0]                    r_ac_prot;
  logic [4:0]                    r_crresp;
  logic [DataWidth*CdBeats-1:0]  r_data;
  logic                          r_err;
  logic [CntW-1:0]               r_cnt;

  logic w_req_hs, w_ac_hs, w_cr_hs, w_cd_hs, w_rsp_hs, w_cd_final;

  assign w_req_hs   = r_req_ready & req_valid_i;
  assign w_ac_hs    = r_ac_valid & ac_ready_i;
  assign w_cr_hs    = r_cr_ready & cr_valid_i;
  assign w_cd_hs    = r_cd_ready & cd_valid_i;
  assign w_rsp_hs   = r_rsp_valid & rsp_ready_i;
  assign w_cd_final = (r_cnt == LastCnt);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_req_hs) w_state_nxt = S_AC;
      S_AC:   if (w_ac_hs) w_state_nxt = S_CR;
      S_CR:   if (w_cr_hs) w_state_nxt = cr_resp_i[0] ? S_CD : S_RSP;
      S_CD:   if (w_cd_hs && w_cd_final) w_state_nxt = S_RSP;
      S_RSP:  if (w_rsp_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_ac_valid  <= 1'b0;
      r_cr_ready  <= 1'b0;
      r_cd_ready  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_ac_addr   <= '0;
      r_ac_snoop  <= '0;
      r_ac_prot   <= '0;
      r_crresp    <= '0;
      r_data      <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_ac_valid  <= (w_state_nxt == S_AC);
      r_cr_ready  <= (w_state_nxt == S_CR);
      r_cd_ready  <= (w_state_nxt == S_CD);
      r_rsp_valid <= (w_state_nxt == S_RSP);
      if (w_req_hs) begin
        r_ac_addr  <= req_addr_i;
        r_ac_snoop <= req_snoop_i;
        r_ac_prot  <= req_prot_i;
        r_crresp   <= '0;
        r_data     <= '0;
        r_err      <= 1'b0;
        r_cnt      <= '0;
      end
      if (w_cr_hs) r_crresp <= cr_resp_i;
      // Early or missing last flags an error but never shortens the line.
      if (w_cd_hs) begin
        r_data[r_cnt*DataWidth +: DataWidth] <= cd_data_i;
        r_cnt <= w_cd_final ? '0 : r_cnt + 1'b1;
        if (w_cd_final ? !cd_last_i : cd_last_i) r_err <= 1'b1;
      end
    end
  end

  assign req_ready_o  = r_req_ready;
  assign ac_valid_o   = r_ac_valid;
  assign ac_addr_o    = r_ac_addr;
  assign ac_snoop_o   = r_ac_snoop;
  assign ac_prot_o    = r_ac_prot;
  assign cr_ready_o   = r_cr_ready;
  assign cd_ready_o   = r_cd_ready;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_crresp_o = r_crresp;
  assign rsp_data_o   = r_data;
  assign rsp_err_o    = r_err;

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// tb/tb_ace_snoop_initiator.sv - directed table-driven bench for ace_snoop_initiator.
module tb_ace_snoop_initiator;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [63:0]  req_addr = '0;
  logic [3:0]   req_snoop = '0;
  logic [2:0]   req_prot = '0;
  logic         ac_valid;
  logic         ac_ready = 1'b0;
  logic [63:0]  ac_addr;
  logic [3:0]   ac_snoop;
  logic [2:0]   ac_prot;
  logic         cr_valid = 1'b0;
  logic         cr_ready;
  logic [4:0]   cr_resp = '0;
  logic         cd_valid = 1'b0;
  logic         cd_ready;
  logic [63:0]  cd_data = '0;
  logic         cd_last = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [4:0]   rsp_crresp;
  logic [127:0] rsp_data;
  logic         rsp_err;

  int n_cmp = 0;
  int n_err = 0;
  int ac_hs = 0;
  int cd_hs = 0;

  always #5 clk = ~clk;

  ace_snoop_initiator dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_snoop_i(req_snoop), .req_prot_i(req_prot),
    .ac_valid_o(ac_valid), .ac_ready_i(ac_ready),
    .ac_addr_o(ac_addr), .ac_snoop_o(ac_snoop), .ac_prot_o(ac_prot),
    .cr_valid_i(cr_valid), .cr_ready_o(cr_ready), .cr_resp_i(cr_resp),
    .cd_valid_i(cd_valid), .cd_ready_o(cd_ready), .cd_data_i(cd_data), .cd_last_i(cd_last),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_crresp_o(rsp_crresp), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err)
  );

  always @(posedge clk) begin
    if (!rst) begin
      if (ac_valid && ac_ready) ac_hs++;
      if (cd_valid && cd_ready) cd_hs++;
    end
  end

  typedef struct {
    logic [63:0]  addr;
    logic [3:0]   snoop;
    logic [2:0]   prot;
    logic [4:0]   resp;
    logic [63:0]  d0;
    logic         l0;
    logic [63:0]  d1;
    logic         l1;
    logic [127:0] exp_data;
    logic         exp_err;
    int           ac_stall;
    int           cd_gap;
    int           rsp_hold;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input vec_t v);
    for (int k = 0; k < 20 && !req_ready; k++) tick();
    chk("req_ready_before_cmd", req_ready, 1'b1);
    req_valid = 1'b1; req_addr = v.addr; req_snoop = v.snoop; req_prot = v.prot;
    tick();
    req_valid = 1'b0;
    chk("ac_valid_n_plus_1", ac_valid, 1'b1);
    chk("req_ready_busy", req_ready, 1'b0);
    chk("ac_payload", {ac_addr, ac_snoop, ac_prot}, {v.addr, v.snoop, v.prot});
  endtask

  task automatic do_ac_cr(input vec_t v);
    int base;
    base = ac_hs;
    for (int k = 0; k < v.ac_stall; k++) begin
      tick();
      chk("ac_valid_stall", ac_valid, 1'b1);
      chk("ac_payload_stall", {ac_addr, ac_snoop, ac_prot}, {v.addr, v.snoop, v.prot});
    end
    ac_ready = 1'b1;
    tick();
    ac_ready = 1'b0;
    chk("ac_handshakes", ac_hs - base, 1);
    chk("ac_valid_drop", ac_valid, 1'b0);
    chk("cr_ready", cr_ready, 1'b1);
    cr_valid = 1'b1; cr_resp = v.resp;
    tick();
    cr_valid = 1'b0;
  endtask

  task automatic send_beat(input int gap, input logic [63:0] d, input logic l);
    for (int k = 0; k < gap; k++) tick();
    cd_valid = 1'b1; cd_data = d; cd_last = l;
    tick();
    cd_valid = 1'b0; cd_last = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int base;
    send_cmd(v);
    do_ac_cr(v);
    base = cd_hs;
    if (v.resp[0]) begin
      chk("cd_ready", cd_ready, 1'b1);
      send_beat(v.cd_gap, v.d0, v.l0);
      send_beat(v.cd_gap, v.d1, v.l1);
    end
    for (int k = 0; k < 10 && !rsp_valid; k++) tick();
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("cd_beats", cd_hs - base, v.resp[0] ? 2 : 0);
    chk("rsp_crresp", rsp_crresp, v.resp);
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_err", rsp_err, v.exp_err);
    for (int k = 0; k < v.rsp_hold; k++) begin
      req_valid = 1'b1;
      tick();
      chk("rsp_hold_stable", {rsp_valid, rsp_data, rsp_crresp}, {1'b1, v.exp_data, v.resp});
      chk("rsp_hold_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 1'b0);
    chk("req_ready_m_plus_1", req_ready, 1'b1);
  endtask

  initial begin
    vecs[0] = '{64'h8000_0040, 4'h1, 3'd0, 5'b00000, 64'h0, 1'b0, 64'h0, 1'b0, 128'h0, 1'b0, 0, 0, 0};
    vecs[1] = '{64'h8000_0080, 4'h7, 3'd2, 5'b00101, 64'h1111, 1'b0, 64'h2222, 1'b1,
                {64'h2222, 64'h1111}, 1'b0, 0, 0, 0};
    vecs[2] = '{64'h1234_5678_9ABC_DEF0, 4'h9, 3'd5, 5'b00101, 64'h3333, 1'b0, 64'h4444, 1'b1,
                {64'h4444, 64'h3333}, 1'b0, 4, 3, 0};
    vecs[3] = '{64'h0000_0100, 4'h2, 3'd1, 5'b00001, 64'hAAAA, 1'b1, 64'hBBBB, 1'b0,
                {64'hBBBB, 64'hAAAA}, 1'b1, 0, 0, 0};
    vecs[4] = '{64'h0000_0140, 4'h1, 3'd0, 5'b01010, 64'h0, 1'b0, 64'h0, 1'b0, 128'h0, 1'b0, 1, 0, 0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFC0, 4'hD, 3'd7, 5'b10011, 64'hDEAD_BEEF_0000_0001, 1'b0,
                64'hCAFE_F00D_0000_0002, 1'b1,
                {64'hCAFE_F00D_0000_0002, 64'hDEAD_BEEF_0000_0001}, 1'b0, 0, 1, 5};
    vecs[6] = '{64'h0000_0200, 4'h3, 3'd4, 5'b00001, 64'h5555, 1'b0, 64'h6666, 1'b0,
                {64'h6666, 64'h5555}, 1'b1, 0, 0, 0};

    #2;
    chk("reset_outputs", {req_ready, ac_valid, cr_ready, cd_ready, rsp_valid, rsp_err},
        6'b0);
    chk("reset_payload", {ac_addr, ac_snoop, ac_prot, rsp_crresp}, '0);
    chk("reset_data", rsp_data, 128'h0);
    #20 rst = 1'b0;
    tick();
    chk("req_ready_after_reset", req_ready, 1'b1);

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Reset in the middle of CD collection, then a clean data snoop.
    send_cmd(vecs[1]);
    do_ac_cr(vecs[1]);
    send_beat(0, 64'h7777, 1'b0);
    rst = 1'b1;
    #1;
    chk("midcd_reset_ctrl", {req_ready, ac_valid, cr_ready, cd_ready, rsp_valid, rsp_err}, 6'b0);
    chk("midcd_reset_payload", {ac_addr, ac_snoop, ac_prot, rsp_crresp}, '0);
    chk("midcd_reset_data", rsp_data, 128'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    chk("req_ready_after_midcd", req_ready, 1'b1);
    run_txn(vecs[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
